id_hazard_controller: RTL and testbench

Sequencing controller for the instruction-decode stage. It produces the pipeline write-enable, bubble and flush controls around the decode datapath (decoder, register file, sign-extend) and the IF/ID and ID/EX registers. Its three jobs are load-use stalls, taken-branch flushes, and multi-cycle mult/div occupancy of EX. It also keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/id_hazard_controller.sv | 135 +++++++++++++
 tb/tb_id_hazard_controller.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_controller.sv
// Decode-stage sequencing controller: load-use stalls, taken-branch flushes,
// multi-cycle mult/div occupancy of EX, and a saturating stall-cycle counter.
//
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_id_*          : ID instruction (valid, rs, rt, uses_rt, is_md)
//   i_ex_*          : EX instruction (valid, mem_read, dest)
//   i_branch_taken  : branch resolved taken in EX this cycle
//   o_pc_write, o_ifid_write, o_ifid_flush, o_idex_write, o_idex_bubble,
//   o_exmem_bubble  : pipeline register controls (combinational)
//   o_busy          : mult/div occupying EX
//   o_stall_cycles  : saturating count of stalled cycles
module id_hazard_controller #(
    parameter int unsigned MD_CYCLES = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_id_valid,
    input  logic [4:0]  i_id_rs,
    input  logic [4:0]  i_id_rt,
    input  logic        i_id_uses_rt,
    input  logic        i_id_is_md,
    input  logic        i_ex_valid,
    input  logic        i_ex_mem_read,
    input  logic [4:0]  i_ex_dest,
    input  logic        i_branch_taken,
    output logic        o_pc_write,
    output logic        o_ifid_write,
    output logic        o_ifid_flush,
    output logic        o_idex_write,
    output logic        o_idex_bubble,
    output logic        o_exmem_bubble,
    output logic        o_busy,
    output logic [15:0] o_stall_cycles
);

    localparam int unsigned CNT_W  = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;
    localparam int unsigned STAT_W = 16;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    md_cnt_q, md_cnt_d;
    logic [STAT_W-1:0]   stall_q, stall_d;
    logic                load_use;
    logic                count_stall;

    // Register zero never carries a hazard.
    always_comb begin
        load_use = i_id_valid & i_ex_valid & i_ex_mem_read & (i_ex_dest != 5'd0) &
                   ((i_ex_dest == i_id_rs) | (i_id_uses_rt & (i_ex_dest == i_id_rt)));
    end

    // State, mult/div countdown and stall counter.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= RUN;
            md_cnt_q <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
            stall_q  <= stall_d;
        end
    end

    // Next-state and control outputs.
    always_comb begin
        state_d        = state_q;
        md_cnt_d       = md_cnt_q;
        count_stall    = 1'b0;
        o_pc_write     = 1'b1;
        o_ifid_write   = 1'b1;
        o_ifid_flush   = 1'b0;
        o_idex_write   = 1'b1;
        o_idex_bubble  = 1'b0;
        o_exmem_bubble = 1'b0;
        o_busy         = 1'b0;

        unique case (state_q)
            RUN: begin
                if (i_branch_taken) begin
                    // Cancels the ID instruction, mult/div included.
                    o_ifid_flush  = 1'b1;
                    o_idex_bubble = 1'b1;
                end else if (load_use) begin
                    o_pc_write    = 1'b0;
                    o_ifid_write  = 1'b0;
                    o_idex_bubble = 1'b1;
                    count_stall   = 1'b1;
                end else if (i_id_valid && i_id_is_md) begin
                    // Issue cycle counts as the first EX cycle.
                    state_d  = MD_BUSY;
                    md_cnt_d = CNT_W'(MD_CYCLES - 2);
                end
            end
            MD_BUSY: begin
                o_pc_write     = 1'b0;
                o_ifid_write   = 1'b0;
                o_idex_write   = 1'b0;
                o_exmem_bubble = 1'b1;
                o_busy         = 1'b1;
                count_stall    = 1'b1;
                if (md_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    md_cnt_d = md_cnt_q - CNT_W'(1);
                end
            end
            default: state_d = RUN;
        endcase

        stall_d = stall_q;
        if (count_stall && (stall_q != {STAT_W{1'b1}})) begin
            stall_d = stall_q + STAT_W'(1);
        end

        // Reset forces a safe, pipeline-clearing control pattern.
        if (!i_reset) begin
            o_pc_write     = 1'b0;
            o_ifid_write   = 1'b0;
            o_ifid_flush   = 1'b1;
            o_idex_write   = 1'b0;
            o_idex_bubble  = 1'b1;
            o_exmem_bubble = 1'b1;
            o_busy         = 1'b0;
        end
    end

    assign o_stall_cycles = i_reset ? stall_q : '0;

endmodule

// File: tb/tb_id_hazard_controller.sv
// Testbench for id_hazard_controller: directed stimulus, per-cycle comparison
// against a behavioural model, plus hand-computed literal checks.
module tb_id_hazard_controller;

    localparam int unsigned MD = 4;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_id_valid;
    logic [4:0]  i_id_rs;
    logic [4:0]  i_id_rt;
    logic        i_id_uses_rt;
    logic        i_id_is_md;
    logic        i_ex_valid;
    logic        i_ex_mem_read;
    logic [4:0]  i_ex_dest;
    logic        i_branch_taken;
    logic        o_pc_write;
    logic        o_ifid_write;
    logic        o_ifid_flush;
    logic        o_idex_write;
    logic        o_idex_bubble;
    logic        o_exmem_bubble;
    logic        o_busy;
    logic [15:0] o_stall_cycles;

    id_hazard_controller #(.MD_CYCLES(MD)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_id_valid     (i_id_valid),
        .i_id_rs        (i_id_rs),
        .i_id_rt        (i_id_rt),
        .i_id_uses_rt   (i_id_uses_rt),
        .i_id_is_md     (i_id_is_md),
        .i_ex_valid     (i_ex_valid),
        .i_ex_mem_read  (i_ex_mem_read),
        .i_ex_dest      (i_ex_dest),
        .i_branch_taken (i_branch_taken),
        .o_pc_write     (o_pc_write),
        .o_ifid_write   (o_ifid_write),
        .o_ifid_flush   (o_ifid_flush),
        .o_idex_write   (o_idex_write),
        .o_idex_bubble  (o_idex_bubble),
        .o_exmem_bubble (o_exmem_bubble),
        .o_busy         (o_busy),
        .o_stall_cycles (o_stall_cycles)
    );

    always #5 i_clk = ~i_clk;

    // Control vector order: {pc, ifid_w, ifid_flush, idex_w, idex_bubble, exmem_bubble, busy}
    localparam logic [6:0] C_RESET = 7'b0010110;
    localparam logic [6:0] C_RUN   = 7'b1101000;
    localparam logic [6:0] C_LU    = 7'b0001100;
    localparam logic [6:0] C_BR    = 7'b1111100;
    localparam logic [6:0] C_BUSY  = 7'b0000011;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: remaining busy cycles and stall tally.
    int busy_left = 0;
    int stall_cnt = 0;

    logic [6:0]  last_ctl;
    logic [15:0] last_stall;

    function automatic logic [6:0] dut_ctl();
        return {o_pc_write, o_ifid_write, o_ifid_flush, o_idex_write,
                o_idex_bubble, o_exmem_bubble, o_busy};
    endfunction

    function automatic bit hazard();
        bit src_match;
        src_match = (i_ex_dest == i_id_rs) || (i_id_uses_rt && (i_ex_dest == i_id_rt));
        return i_id_valid && i_ex_valid && i_ex_mem_read && (i_ex_dest != 0) && src_match;
    endfunction

    function automatic logic [6:0] model_ctl();
        if (!i_reset)         return C_RESET;
        if (busy_left > 0)    return C_BUSY;
        if (i_branch_taken)   return C_BR;
        if (hazard())         return C_LU;
        return C_RUN;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: sample and compare mid-cycle, then advance the model at the edge.
    task automatic tick();
        logic [6:0]  exp_ctl;
        logic [15:0] exp_stall;
        @(negedge i_clk);
        exp_ctl   = model_ctl();
        exp_stall = i_reset ? 16'(stall_cnt) : 16'd0;
        last_ctl   = dut_ctl();
        last_stall = o_stall_cycles;
        check("cycle_ctl", 32'(last_ctl), 32'(exp_ctl));
        check("cycle_stall", 32'(last_stall), 32'(exp_stall));
        @(posedge i_clk);
        if (!i_reset) begin
            busy_left = 0;
            stall_cnt = 0;
        end else if (busy_left > 0) begin
            busy_left--;
            stall_cnt = (stall_cnt < 65535) ? stall_cnt + 1 : 65535;
        end else if (i_branch_taken) begin
            busy_left = 0;
        end else if (hazard()) begin
            stall_cnt = (stall_cnt < 65535) ? stall_cnt + 1 : 65535;
        end else if (i_id_valid && i_id_is_md) begin
            busy_left = MD - 1;
        end
        #1;
    endtask

    task automatic set_idle();
        i_id_valid     = 1'b1;
        i_id_rs        = 5'd1;
        i_id_rt        = 5'd2;
        i_id_uses_rt   = 1'b1;
        i_id_is_md     = 1'b0;
        i_ex_valid     = 1'b1;
        i_ex_mem_read  = 1'b0;
        i_ex_dest      = 5'd3;
        i_branch_taken = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] dest, input logic [4:0] rs,
                            input logic [4:0] rt, input logic uses_rt);
        set_idle();
        i_ex_mem_read = 1'b1;
        i_ex_dest     = dest;
        i_id_rs       = rs;
        i_id_rt       = rt;
        i_id_uses_rt  = uses_rt;
    endtask

    initial begin
        int busy_seen;
        i_reset = 1'b0;
        set_idle();

        // Reset forces the control pattern and clears the counter.
        tick();
        tick();
        check("reset_ctl", 32'(last_ctl), 32'(C_RESET));
        check("reset_stall", 32'(last_stall), 32'd0);
        i_reset = 1'b1;
        tick();
        check("run_after_reset", 32'(last_ctl), 32'(C_RUN));

        // Load-use on RS: one stall cycle, then normal issue.
        set_load(5'd5, 5'd5, 5'd9, 1'b1);
        tick();
        check("lu_rs_ctl", 32'(last_ctl), 32'(C_LU));
        set_idle();
        i_ex_valid = 1'b0;
        tick();
        check("lu_release_ctl", 32'(last_ctl), 32'(C_RUN));
        check("lu_stall_cnt", 32'(last_stall), 32'd1);

        // No false hazards: r0, and RT match with uses_rt=0.
        set_load(5'd0, 5'd0, 5'd0, 1'b1);
        tick();
        check("no_hz_r0", 32'(last_ctl), 32'(C_RUN));
        set_load(5'd7, 5'd1, 5'd7, 1'b0);
        tick();
        check("no_hz_rt_unused", 32'(last_ctl), 32'(C_RUN));
        set_load(5'd7, 5'd1, 5'd7, 1'b1);
        tick();
        check("lu_rt_ctl", 32'(last_ctl), 32'(C_LU));
        set_idle();
        tick();
        check("stall_after_rt", 32'(last_stall), 32'd2);

        // Branch outranks load-use and is not counted.
        set_load(5'd5, 5'd5, 5'd9, 1'b1);
        i_branch_taken = 1'b1;
        i_id_is_md     = 1'b1;
        tick();
        check("branch_ctl", 32'(last_ctl), 32'(C_BR));
        set_idle();
        tick();
        check("branch_no_md", 32'(last_ctl), 32'(C_RUN));
        check("branch_no_stall", 32'(last_stall), 32'd2);

        // Mult/div: issue, then MD-1 busy cycles.
        i_id_is_md = 1'b1;
        tick();
        check("md_issue_ctl", 32'(last_ctl), 32'(C_RUN));
        set_idle();
        busy_seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (last_ctl == C_BUSY) busy_seen++;
        end
        check("md_busy_cycles", 32'(busy_seen), 32'd3);
        check("md_stall_cnt", 32'(last_stall), 32'd5);

        // Back-to-back mult/div: re-issue in the first RUN cycle.
        i_id_is_md = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) tick();
        check("b2b_last_busy", 32'(last_ctl), 32'(C_BUSY));
        tick();
        check("b2b_reissue", 32'(last_ctl), 32'(C_RUN));
        set_idle();
        tick();
        check("b2b_busy_again", 32'(last_ctl), 32'(C_BUSY));
        tick();
        tick();
        tick();
        check("b2b_done", 32'(last_ctl), 32'(C_RUN));
        check("b2b_stall_cnt", 32'(last_stall), 32'd11);

        // Reset during the second busy cycle aborts the operation.
        i_id_is_md = 1'b1;
        tick();
        set_idle();
        tick();
        check("pre_abort_busy", 32'(last_ctl), 32'(C_BUSY));
        i_reset = 1'b0;
        tick();
        check("abort_ctl", 32'(last_ctl), 32'(C_RESET));
        check("abort_stall", 32'(last_stall), 32'd0);
        i_reset = 1'b1;
        tick();
        check("after_abort_ctl", 32'(last_ctl), 32'(C_RUN));
        check("after_abort_stall", 32'(last_stall), 32'd0);

        // Saturation: hold a load-use hazard long enough to pass 0xFFFF.
        set_load(5'd5, 5'd5, 5'd9, 1'b1);
        for (int k = 0; k < 65540; k++) tick();
        check("sat_value", 32'(last_stall), 32'h0000FFFF);
        tick();
        tick();
        check("sat_hold", 32'(last_stall), 32'h0000FFFF);
        set_idle();
        tick();
        check("sat_release_ctl", 32'(last_ctl), 32'(C_RUN));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
